// File: rtl/quad_counter_pkg.sv
// Shared definitions for the quadrature counter bank.
//   step_e     : result of comparing two consecutive filtered A/B pairs
//   FILT_CW    : width of the per-channel noise-filter run counter
//   gray_pos() : position (0..3) of an A/B pair on the Gray cycle 00,01,11,10
//   gray_step(): classify a pair change as none / +1 / -1 / illegal
//   sel_w()    : channel-select width, never less than one bit
package quad_counter_pkg;

  // Encoded as the modulo-4 distance walked around the Gray cycle, so the
  // decoder is just a subtraction of two positions.
  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_INC  = 2'd1,
    STEP_ILL  = 2'd2,
    STEP_DEC  = 2'd3
  } step_e;

  localparam int FILT_CW = 4;

  function automatic logic [1:0] gray_pos(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'd0;
      2'b01:   return 2'd1;
      2'b11:   return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  function automatic step_e gray_step(input logic [1:0] prev, input logic [1:0] cur);
    logic [1:0] d;
    d = gray_pos(cur) - gray_pos(prev);
    return step_e'(d);
  endfunction

  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/quad_channel.sv
// One quadrature channel: two-flop synchronizer, run-length noise filter,
// Gray step decoder, wrapping up/down counter and sticky illegal flag.
//   clk, rst   : clock, synchronous active-high reset
//   ab_i       : raw encoder pair {A,B}, asynchronous to clk
//   err_clr_i  : clear the sticky error flag (a same-edge illegal step wins)
//   cnt_o      : current count, wraps modulo 2^CW
//   err_o      : sticky illegal-transition flag
// A clean input step reaches cnt_o FLEN+3 edges after it is first sampled:
// two synchronizer edges, FLEN filter edges, one decode edge.
module quad_channel
  import quad_counter_pkg::*;
#(
  parameter int FLEN = 1,
  parameter int CW   = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    ab_i,
  input  logic          err_clr_i,
  output logic [CW-1:0] cnt_o,
  output logic          err_o
);

  logic [1:0]         sync1_q, sync2_q;
  logic [1:0]         cand_q, cand_d;
  logic [FILT_CW-1:0] run_q, run_d, run_inc;
  logic [1:0]         filt_q, filt_d, prev_q;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               err_q, err_d;
  step_e              dec;

  // run_q counts consecutive edges on which the synchronized pair has shown
  // the same value (cand_q) differing from the filtered pair. Any return to
  // the filtered value, or a switch to another value, restarts the run.
  always_comb begin
    cand_d  = cand_q;
    run_d   = run_q;
    filt_d  = filt_q;
    run_inc = (run_q != '0 && sync2_q == cand_q) ? run_q + 1'b1 : FILT_CW'(1);
    if (sync2_q == filt_q) begin
      run_d = '0;
    end else begin
      cand_d = sync2_q;
      if (run_inc >= FILT_CW'(FLEN)) begin
        filt_d = sync2_q;
        run_d  = '0;
      end else begin
        run_d = run_inc;
      end
    end
  end

  // prev_q trails filt_q by one edge; decoding the pair of registers keeps
  // the counter path free of the filter's combinational logic.
  always_comb begin
    dec   = gray_step(prev_q, filt_q);
    cnt_d = cnt_q;
    err_d = err_clr_i ? 1'b0 : err_q;
    case (dec)
      STEP_INC: cnt_d = cnt_q + 1'b1;
      STEP_DEC: cnt_d = cnt_q - 1'b1;
      STEP_ILL: err_d = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cand_q  <= '0;
      run_q   <= '0;
      filt_q  <= '0;
      prev_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      sync1_q <= ab_i;
      sync2_q <= sync1_q;
      cand_q  <= cand_d;
      run_q   <= run_d;
      filt_q  <= filt_d;
      prev_q  <= filt_q;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign cnt_o = cnt_q;
  assign err_o = err_q;

endmodule

// File: rtl/quad_counter_bank.sv
// Bank of NC quadrature counters with a common snapshot and a tristate
// readout port.
//   clk, rst : clock, synchronous active-high reset
//   q        : encoder pairs, channel i on q[2i+1:2i] (A is the upper bit)
//   latch    : copy every channel's count into its snapshot register
//   err_clr  : clear all sticky error flags
//   oe, sel  : readout enable and channel select
//   countout : snapshot[sel], full or quarter resolution per FULL_MASK;
//              zero for sel >= NC, high-Z while oe = 0
//   err      : per-channel sticky illegal-transition flags
module quad_counter_bank
  import quad_counter_pkg::*;
#(
  parameter int              NC        = 4,
  parameter int              CW        = 16,
  parameter int              OW        = 8,
  parameter logic [NC-1:0]   FULL_MASK = 4'b0011,
  parameter logic [4*NC-1:0] FILTER    = {4'd1, 4'd1, 4'd4, 4'd4}
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2*NC-1:0]        q,
  input  logic                   latch,
  input  logic                   err_clr,
  input  logic                   oe,
  input  logic [sel_w(NC)-1:0]   sel,
  output logic [OW-1:0]          countout,
  output logic [NC-1:0]          err
);

  localparam int SW   = sel_w(NC);
  localparam int NSEL = 1 << SW;
  localparam logic [NSEL-1:0] FULL_PAD = NSEL'(FULL_MASK);

  logic [NC-1:0][CW-1:0]   cnt;
  logic [NC-1:0][CW-1:0]   snap_q, snap_d;
  logic [NSEL-1:0][OW-1:0] view;
  logic [NC-1:0]           unused_snap;

  for (genvar i = 0; i < NC; i++) begin : g_ch
    quad_channel #(
      .FLEN (int'(FILTER[4*i +: 4])),
      .CW   (CW)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .ab_i      (q[2*i +: 2]),
      .err_clr_i (err_clr),
      .cnt_o     (cnt[i]),
      .err_o     (err[i])
    );
  end

  // Snapshot samples the registered counts, so a count update on the latch
  // edge lands in the counter while the snapshot keeps the old value.
  always_comb snap_d = latch ? cnt : snap_q;

  always_ff @(posedge clk) begin
    if (rst) snap_q <= '0;
    else     snap_q <= snap_d;
  end

  // The select space is padded to a power of two; unused slots read zero.
  for (genvar i = 0; i < NSEL; i++) begin : g_view
    if (i >= NC) begin : g_pad
      assign view[i] = '0;
    end else if (FULL_PAD[i]) begin : g_full
      assign view[i] = snap_q[i][OW-1:0];
    end else begin : g_qtr
      assign view[i] = snap_q[i][OW+1:2];
    end
  end

  // Upper snapshot bits carry the full wrap state but are never shown.
  for (genvar i = 0; i < NC; i++) begin : g_unused
    assign unused_snap[i] = ^snap_q[i];
  end

  assign countout = oe ? view[sel] : {OW{1'bz}};

endmodule

// File: doc/quad_counter_bank.md
QUAD_COUNTER_BANK -- requirements
Module: quad_counter_bank

Interface
REQ-001 SHALL have parameter NC, default 4: number of quadrature channels (1..16).
REQ-002 SHALL have parameter CW, default 16: internal count width per channel (OW+2..32).
REQ-003 SHALL have parameter OW, default 8: countout width.
REQ-004 SHALL have parameter FULL_MASK, default 4'b0011 ([NC-1:0]): bit i=1 selects full-resolution output for channel i; 0 selects quarter resolution.
REQ-005 SHALL have parameter FILTER, default {4'd1,4'd1,4'd4,4'd4} (4 bits per channel, channel 0 in LSBs): noise filter length, 1..15; 1 means no filtering.
REQ-006 SHALL have port clk, input, 1: sole clock; all state on rising edge.
REQ-007 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-008 SHALL have port q, input, 2*NC: encoder A/B pairs; channel i on q[2i+1:2i], bit 2i+1 = A; asynchronous to clk.
REQ-009 SHALL have port latch, input, 1: snapshot strobe, one-cycle pulse.
REQ-010 SHALL have port err_clr, input, 1: clears all sticky error flags.
REQ-011 SHALL have port oe, input, 1: output enable for countout.
REQ-012 SHALL have port sel, input, max(1,$clog2(NC)): channel select for countout.
REQ-013 SHALL have port countout, output, OW: selected snapshot value; high-Z when oe=0.
REQ-014 SHALL have port err, output, NC: per-channel sticky illegal-transition flags.

Function
REQ-015 SHALL pass each q bit through a two-flop synchronizer before any other use.
REQ-016 SHALL update channel i's filtered pair only after its synchronized pair has held the same new value for FILTER[i] consecutive clk edges; shorter glitches SHALL be ignored.
REQ-017 SHALL decode Gray-code steps of the filtered pair: 00->01->11->10->00 = +1, reverse = -1, each per filtered change.
REQ-018 SHALL treat a filtered change of both bits (00<->11, 01<->10) as illegal: count unchanged, err[i] set.
REQ-019 SHALL wrap counts modulo 2^CW in both directions without saturation or flags.
REQ-020 SHALL update the count exactly FILTER[i]+3 edges after a clean q step that is stable through the sampling edge.
REQ-021 SHALL, on the edge where latch=1, copy all NC counts into snapshot registers simultaneously, using the pre-edge count values.
REQ-022 SHALL derive countout combinationally from snapshot[sel]: bits [OW-1:0] if FULL_MASK[sel]=1, else bits [OW+1:2].
REQ-023 SHALL drive countout to all-Z when oe=0; sel SHALL be a don't-care then.
REQ-024 SHALL drive countout to 0 for sel>=NC with oe=1.
REQ-025 SHALL clear all err bits on the edge where err_clr=1; if an illegal transition occurs on the same edge, set SHALL win.
REQ-026 SHALL let latch and a count update on the same edge both occur, with the snapshot taking the old count.

Reset
REQ-027 SHALL, on an edge with rst=1, zero all counts, snapshots, err and filter counters, and load synchronizers and filtered pairs with 00.
REQ-028 SHALL abort any partially qualified filter run when rst asserts mid-run.
REQ-029 SHALL drive countout=0 when oe=1 and err=0 after reset.
REQ-030 SHALL, after reset release, count a first q change away from 00 normally.

Structure
REQ-031 SHALL place Gray decode constants and helper width functions in shared package quad_counter_pkg.
REQ-032 SHALL implement synchronizer, filter, decoder and counter in sub-module quad_channel, instantiated NC times with FILTER[i] and CW.
REQ-033 SHALL keep snapshot registers, output mux and tristate in the top level.

Verification
REQ-034 SHALL verify: reset, then latch, oe=1, sel=0..3 -> countout=0x00, err=0.
REQ-035 SHALL verify: ch2 (FILTER=1, quarter mode) 40 clean forward steps, latch, sel=2 -> countout=0x0A; ch0 (full mode) 40 forward steps -> countout=0x28.
REQ-036 SHALL verify: ch0 (FILTER=4) A pulse of 3 cycles -> count unchanged; 4 cycles -> count changes FILTER+3=7 edges after the step.
REQ-037 SHALL verify: ch1 one reverse step from reset -> snapshot 0xFFFF, full-mode countout=0xFF; 65536 forward steps -> count returns to start.
REQ-038 SHALL verify: ch3 filtered 00->11 -> err[3]=1, count unchanged; err_clr on same edge as a second illegal step -> err[3] stays 1.
REQ-039 SHALL verify: random per-channel stimulus 100000 cycles against a behavioural model delayed FILTER+3; oe=0 about 1/64 cycles -> countout=Z.
